// File: rtl/fetch_unit_pkg.sv
// Shared constants and buffer entry type for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: registered head, flush clears all entries.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: credit-limited requests, in-order response buffer, redirect drop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic            req_fire;
    logic            resp_in;
    logic            discard;
    logic            enq;
    logic            full;
    logic            empty;
    fetch_entry_t    head;
    fetch_entry_t    wentry;

    assign target   = word_align(redirect_pc);
    assign imem_req_addr = fetch_pc;
    assign imem_req_valid = ~rst & ~redirect_valid & ~full
                          & (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
    assign req_fire = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a leftover from before reset.
    assign resp_in  = imem_resp_valid & ~rst & (outstanding != '0);
    assign discard  = redirect_valid | (drop_cnt != '0);
    assign enq      = resp_in & ~discard;
    assign wentry   = '{pc: resp_pc, inst: imem_resp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_in);
            if (redirect_valid) begin
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outstanding - CW'(resp_in);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (enq)      resp_pc  <= resp_pc + XLEN'(4);
                if (resp_in && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (inst_valid & inst_ready),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign inst_valid = ~empty & ~rst;
    assign inst       = inst_valid ? head.inst : NOP;
    assign pc         = inst_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a sequential-stream memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rdy_pct = 100;
    int          fires = 0;
    int          delivered = 0;
    logic        c_rst = 1'b1;
    logic        c_redir = 1'b0;
    logic        c_irdy = 1'b1;
    logic [31:0] c_rpc = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    logic        cap_first = 1'b0;
    logic [31:0] first_pc = '1;
    logic        s_rv, s_iv, s_respv;
    logic [31:0] s_ra, s_pc, s_inst;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int d;
        s_rv    = imem_req_valid;
        s_ra    = imem_req_addr;
        s_iv    = inst_valid;
        s_pc    = pc;
        s_inst  = inst;
        s_respv = imem_resp_valid;
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_inst_valid", inst_valid, 0);
            chk("rst_inst", inst, NOP);
            chk("rst_pc", pc, 0);
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            return;
        end
        if (!inst_valid) begin
            chk("empty_inst", inst, NOP);
            chk("empty_pc", pc, 0);
        end
        if (redirect_valid) chk("redir_req_valid", imem_req_valid, 0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
        if (inst_valid && inst_ready) begin
            chk("stream_pc", pc, exp_pc);
            chk("stream_inst", inst, mem(exp_pc));
            exp_pc = exp_pc + 4;
            delivered++;
            if (cap_first) begin
                first_pc  = pc;
                cap_first = 1'b0;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            d = cyc + lat;
            if (mq.size() > 0 && mq[$].due >= d) d = mq[$].due + 1;
            mq.push_back('{addr: imem_req_addr, due: d});
            exp_fetch = exp_fetch + 4;
            fires++;
            chk("credit_limit", 32'(mq.size() <= DEPTH), 1);
        end
        if (redirect_valid) begin
            exp_pc    = redirect_pc & ~32'h3;
            exp_fetch = redirect_pc & ~32'h3;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        rst            = c_rst;
        redirect_valid = c_redir;
        redirect_pc    = c_rpc;
        inst_ready     = c_irdy;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem(mq[0].addr);
            void'(mq.pop_front());
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset(input int n);
        c_rst   = 1'b1;
        c_redir = 1'b0;
        repeat (n) cycle();
        c_rst = 1'b0;
    endtask

    initial begin
        int f0;
        int d0;

        // Reset release, latency 1, always ready
        lat = 1; rdy_pct = 100; c_irdy = 1'b1;
        do_reset(3);
        cycle();
        chk("t1_c1_req_valid", s_rv, 1);
        chk("t1_c1_req_addr", s_ra, 32'h0);
        chk("t1_c1_inst_valid", s_iv, 0);
        cycle();
        chk("t1_c2_req_addr", s_ra, 32'h4);
        chk("t1_c2_inst_valid", s_iv, 0);
        cycle();
        chk("t1_c3_req_addr", s_ra, 32'h8);
        chk("t1_c3_inst_valid", s_iv, 1);
        chk("t1_c3_pc", s_pc, 32'h0);
        repeat (5) cycle();

        // Decode stalled: credits run out after DEPTH requests
        c_irdy = 1'b0;
        do_reset(10);
        f0 = fires;
        repeat (12) cycle();
        chk("t2_req_count", fires - f0, 4);
        chk("t2_req_valid", s_rv, 0);
        chk("t2_head_valid", s_iv, 1);
        chk("t2_head_pc", s_pc, 32'h0);
        chk("t2_head_inst", s_inst, 32'h5A5A_0F0F);
        c_irdy = 1'b1;
        d0 = delivered;
        repeat (20) cycle();
        chk("t2_drain", 32'(delivered - d0 >= 8), 1);

        // Latency 3, redirect with two requests in flight
        lat = 3; rdy_pct = 100;
        do_reset(10);
        f0 = fires;
        cycle();
        cycle();
        rdy_pct = 0; c_redir = 1'b1; c_rpc = 32'h100;
        cycle();
        chk("t3_outstanding", fires - f0, 2);
        c_redir = 1'b0; rdy_pct = 100; cap_first = 1'b1;
        d0 = delivered;
        cycle();
        chk("t3_req_addr", s_ra, 32'h100);
        repeat (2) cycle();
        chk("t3_none_early", delivered - d0, 0);
        repeat (10) cycle();
        chk("t3_first_pc", first_pc, 32'h100);

        // Redirect to a misaligned target coinciding with a response
        lat = 2; rdy_pct = 100;
        do_reset(10);
        cycle();
        rdy_pct = 0;
        cycle();
        c_redir = 1'b1; c_rpc = 32'h203;
        cycle();
        chk("t4_resp_coincide", s_respv, 1);
        c_redir = 1'b0; rdy_pct = 100; cap_first = 1'b1;
        cycle();
        chk("t4_req_valid", s_rv, 1);
        chk("t4_req_addr", s_ra, 32'h200);
        repeat (8) cycle();
        chk("t4_first_pc", first_pc, 32'h200);

        // Reset with three requests in flight
        lat = 3; rdy_pct = 100;
        do_reset(10);
        f0 = fires;
        repeat (3) cycle();
        chk("t5_in_flight", 32'(mq.size()), 3);
        do_reset(10);
        chk("t5_drained", 32'(mq.size()), 0);
        cap_first = 1'b1;
        repeat (10) cycle();
        chk("t5_first_pc", first_pc, RESET_PC);

        // Random traffic with redirects, including wrap near 2^32
        rdy_pct = 70;
        do_reset(10);
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            lat    = $urandom_range(1, 4);
            c_irdy = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
                c_redir = 1'b1;
                c_rpc   = ($urandom_range(3) == 0)
                        ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                        : $urandom();
            end else begin
                c_redir = 1'b0;
            end
            cycle();
        end
        c_redir = 1'b0;
        chk("rand_progress", 32'(delivered - d0 > 300), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
